// File: rtl/bp_gshare.sv
// bp_gshare: gshare branch predictor for the fetch stage.
// Table of 2^IDX_W saturating counters (CNT_W bits, prediction = MSB), indexed by
// PC XOR speculative global history. Predictions are combinational. Counters are
// trained at commit, and the history is repaired on a misprediction.
// Build option: define BP_GSHARE_EN for gshare indexing. Without it the block is a
// bimodal predictor: no history register, pred_ghr tied to 0, u_ghr/u_mispredict ignored.
module bp_gshare #(
    parameter int unsigned IDX_W = 8,
    parameter int unsigned CNT_W = 2,
    parameter int unsigned GHR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             q_valid,
    input  logic [31:0]      q_pc,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_index,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             u_valid,
    input  logic [IDX_W-1:0] u_index,
    input  logic [GHR_W-1:0] u_ghr,
    input  logic             u_taken,
    input  logic             u_mispredict
);

    localparam int unsigned Depth = 1 << IDX_W;
    // Weakly not-taken: 2^(CNT_W-1)-1.
    localparam logic [CNT_W-1:0] CntInit = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic [CNT_W-1:0] table_q [Depth];
    logic [CNT_W-1:0] upd_cnt;
    logic [CNT_W-1:0] upd_cnt_d;
    logic [IDX_W-1:0] pc_idx;

    assign pc_idx  = q_pc[IDX_W+1:2];
    assign upd_cnt = table_q[u_index];

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;
    // The top bit of each concatenation is the history bit that falls off the end.
    logic [GHR_W:0]   shift_cat;
    logic [GHR_W:0]   repair_cat;
    logic             unused_bits;

    assign pred_index  = pc_idx ^ IDX_W'(ghr_q);
    assign pred_ghr    = ghr_q;
    assign shift_cat   = {ghr_q, pred_taken};
    assign repair_cat  = {u_ghr, u_taken};
    assign unused_bits = ^{q_pc[31:IDX_W+2], q_pc[1:0], shift_cat[GHR_W], repair_cat[GHR_W]};

    // History next state: repair beats the speculative shift (that query is being flushed).
    always_comb begin
        ghr_d = ghr_q;
        if (rdy) begin
            if (u_valid && u_mispredict) begin
                ghr_d = repair_cat[GHR_W-1:0];
            end else if (q_valid) begin
                ghr_d = shift_cat[GHR_W-1:0];
            end
        end
    end

    // History register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    logic unused_bits;

    assign pred_index  = pc_idx;
    assign pred_ghr    = '0;
    assign unused_bits = ^{q_pc[31:IDX_W+2], q_pc[1:0], q_valid, u_ghr, u_mispredict};
`endif

    // Prediction reads the pre-update counter, so a same-index update is seen next cycle.
    assign pred_taken = table_q[pred_index][CNT_W-1];

    // Saturating increment/decrement of the counter being trained.
    always_comb begin
        upd_cnt_d = upd_cnt;
        if (u_taken) begin
            if (upd_cnt != '1) begin
                upd_cnt_d = upd_cnt + 1'b1;
            end
        end else begin
            if (upd_cnt != '0) begin
                upd_cnt_d = upd_cnt - 1'b1;
            end
        end
    end

    // Counter table: reset to weakly not-taken, train one entry per cycle when not stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                table_q[i] <= CntInit;
            end
        end else if (rdy && u_valid) begin
            table_q[u_index] <= upd_cnt_d;
        end
    end

endmodule

// File: tb/tb_bp_gshare.sv
// Self-checking bench for bp_gshare (default parameters). Expectations adapt to
// whether BP_GSHARE_EN is defined; the bimodal build expects pred_index = q_pc[9:2].
module tb_bp_gshare;

`ifdef BP_GSHARE_EN
    localparam bit GS = 1'b1;
`else
    localparam bit GS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        q_valid;
    logic [31:0] q_pc;
    logic        pred_taken;
    logic [7:0]  pred_index;
    logic [7:0]  pred_ghr;
    logic        u_valid;
    logic [7:0]  u_index;
    logic [7:0]  u_ghr;
    logic        u_taken;
    logic        u_mispredict;

    always #5 clk = ~clk;

    bp_gshare #(
        .IDX_W(8),
        .CNT_W(2),
        .GHR_W(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .q_valid      (q_valid),
        .q_pc         (q_pc),
        .pred_taken   (pred_taken),
        .pred_index   (pred_index),
        .pred_ghr     (pred_ghr),
        .u_valid      (u_valid),
        .u_index      (u_index),
        .u_ghr        (u_ghr),
        .u_taken      (u_taken),
        .u_mispredict (u_mispredict)
    );

    typedef struct {
        logic       taken;
        logic [7:0] idx;
        logic [7:0] ghr;
        string      name;
    } exp_t;

    typedef struct {
        logic uv;
        logic ut;
        logic exp_taken;
    } sat_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Drive one cycle's inputs just after the falling edge.
    task automatic drive(input logic r, input logic rd, input logic qv, input logic [31:0] pc,
                         input logic uv, input logic [7:0] ui, input logic [7:0] ug,
                         input logic ut, input logic um);
        @(negedge clk);
        rst          = r;
        rdy          = rd;
        q_valid      = qv;
        q_pc         = pc;
        u_valid      = uv;
        u_index      = ui;
        u_ghr        = ug;
        u_taken      = ut;
        u_mispredict = um;
    endtask

    task automatic expect_out(input logic t, input logic [7:0] i, input logic [7:0] g,
                              input string n);
        exp_t e;
        e.taken = t;
        e.idx   = i;
        e.ghr   = g;
        e.name  = n;
        sb.push_back(e);
    endtask

    // Outputs are combinational; sample 1 time unit after driving, far from the rising edge.
    task automatic check_out();
        exp_t e;
        #1;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sb.pop_front();
        if (pred_taken !== e.taken || pred_index !== e.idx || pred_ghr !== e.ghr) begin
            failures++;
            $display("FAIL %s: got taken=%0b idx=%02h ghr=%02h, want taken=%0b idx=%02h ghr=%02h",
                     e.name, pred_taken, pred_index, pred_ghr, e.taken, e.idx, e.ghr);
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic qv, input logic [31:0] pc,
                        input logic uv, input logic [7:0] ui, input logic [7:0] ug,
                        input logic ut, input logic um,
                        input logic et, input logic [7:0] ei, input logic [7:0] eg,
                        input string n);
        drive(r, rd, qv, pc, uv, ui, ug, ut, um);
        expect_out(et, ei, eg, n);
        check_out();
    endtask

    initial begin
        sat_t        sat[9];
        logic [7:0]  idx;
        logic [31:0] pc;

        // Saturation at index 0x40 (pc 0x100, GHR stays 0 since q_valid=0).
        sat[0] = '{uv: 1'b1, ut: 1'b1, exp_taken: 1'b0};  // 1 -> 2
        sat[1] = '{uv: 1'b1, ut: 1'b1, exp_taken: 1'b1};  // 2 -> 3
        sat[2] = '{uv: 1'b1, ut: 1'b1, exp_taken: 1'b1};  // 3 -> 3
        sat[3] = '{uv: 1'b1, ut: 1'b1, exp_taken: 1'b1};  // 3 -> 3
        sat[4] = '{uv: 1'b1, ut: 1'b0, exp_taken: 1'b1};  // 3 -> 2
        sat[5] = '{uv: 1'b1, ut: 1'b0, exp_taken: 1'b1};  // 2 -> 1
        sat[6] = '{uv: 1'b1, ut: 1'b0, exp_taken: 1'b0};  // 1 -> 0
        sat[7] = '{uv: 1'b1, ut: 1'b0, exp_taken: 1'b0};  // 0 -> 0
        sat[8] = '{uv: 1'b0, ut: 1'b0, exp_taken: 1'b0};  // holds 0

        // Reset, with an update that must be discarded.
        drive(1, 1, 1, 32'h100, 1, 8'h40, 8'h00, 1, 1);

        // Reset state sweep.
        for (int i = 0; i < 16; i++) begin
            idx = 8'((i * 37 + 3) & 255);
            pc  = 32'hABC0_0000 | (32'(idx) << 2) | 32'(i & 3);
            step(0, 1, 0, pc, 0, 0, 0, 0, 0, 0, idx, 8'h00, "reset_sweep");
        end

        for (int i = 0; i < 9; i++) begin
            step(0, 1, 0, 32'h100, sat[i].uv, 8'h40, 8'h00, sat[i].ut, 0,
                 sat[i].exp_taken, 8'h40, 8'h00, $sformatf("saturate_%0d", i));
        end

        // Speculative history: predictions 0,1,1.
        drive(1, 1, 0, 32'h0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'h0, 1, 8'h80, 8'h00, 1, 0, 0, 8'h00, 8'h00, "pretrain_a");
        step(0, 1, 0, 32'h0, 1, 8'hC1, 8'h00, 1, 0, 0, 8'h00, 8'h00, "pretrain_b");
        step(0, 1, 1, 32'h400, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, "ghr_query1");
        step(0, 1, 1, 32'h200, 0, 0, 0, 0, 0, 1, 8'h80, 8'h00, "ghr_query2");
        step(0, 1, 1, 32'h300, 0, 0, 0, 0, 0, GS, GS ? 8'hC1 : 8'hC0,
             GS ? 8'h01 : 8'h00, "ghr_query3");
        step(0, 1, 0, 32'h100, 0, 0, 0, 0, 0, 0, GS ? 8'h43 : 8'h40,
             GS ? 8'h03 : 8'h00, "ghr_index");

        // Repair beats the same-cycle query shift.
        step(0, 1, 1, 32'h100, 1, 8'h20, 8'h5A, 1, 1, 0, GS ? 8'h43 : 8'h40,
             GS ? 8'h03 : 8'h00, "repair_cycle");
        // u_mispredict without u_valid must be ignored.
        step(0, 1, 0, 32'h0, 0, 8'h00, 8'h00, 0, 1, 0, GS ? 8'hB5 : 8'h00,
             GS ? 8'hB5 : 8'h00, "repair_result");
        step(0, 1, 0, GS ? 32'h254 : 32'h80, 0, 0, 0, 0, 0, 1, 8'h20,
             GS ? 8'hB5 : 8'h00, "mispredict_no_valid");

        // Same-index collision: read-before-write.
        drive(1, 1, 0, 32'h0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'h0, 1, 8'h10, 8'h00, 1, 0, 0, 8'h00, 8'h00, "collide_train");
        step(0, 1, 1, 32'h40, 1, 8'h10, 8'h00, 0, 0, 1, 8'h10, 8'h00, "collide_same");
        pc = GS ? 32'h44 : 32'h40;
        step(0, 1, 0, pc, 0, 0, 0, 0, 0, 0, 8'h10, GS ? 8'h01 : 8'h00, "collide_next");

        // Stall: nothing may change.
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, pc, 1, 8'h10, 8'hFF, 1, 1, 0, 8'h10, GS ? 8'h01 : 8'h00,
                 $sformatf("stall_%0d", i));
        end
        step(0, 1, 0, pc, 1, 8'h10, 8'h00, 1, 0, 0, 8'h10, GS ? 8'h01 : 8'h00, "after_stall");
        step(0, 1, 0, pc, 0, 0, 0, 0, 0, 1, 8'h10, GS ? 8'h01 : 8'h00, "trained_pre_rst");

        // Reset has priority over rdy.
        drive(1, 0, 1, pc, 1, 8'h10, 8'h00, 1, 0);
        step(0, 1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 8'h10, 8'h00, "rst_over_rdy");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
